// File: rtl/uart_rx_deser_pkg.sv
// Shared UART definitions for uart_bus, the RX deserializer and the future TX serializer.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_MIN   = 4;

endpackage

// File: rtl/uart_rx_deser_if.sv
// Byte handshake from the RX deserializer into the uart_bus receive port.
interface uart_rx_deser_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deser_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer feeding the uart_bus RX port via valid/ready.
// Define UART_RX_MAJORITY_EN to take each sample as the majority of the last 3 synchronized values.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_MIN = UART_DIV_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  input  logic [DIV_W-1:0] div,
  uart_rx_deser_if.master  rx,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);

  uart_rx_state_e            r_state;
  logic [DIV_W-1:0]          r_cnt;
  logic [DIV_W-1:0]          r_div_l;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_ovr;
  logic                      r_busy;
  logic                      r_rxs_d;

  logic                      w_rxs;
  logic                      w_bit;
  logic                      w_start;
  logic                      w_tick;
  logic [DIV_W-1:0]          w_div_eff;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rxd),
    .o_q   (w_rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_rxs_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxs_d  <= 1'b1;
      r_rxs_d2 <= 1'b1;
    end else begin
      r_rxs_d  <= w_rxs;
      r_rxs_d2 <= r_rxs_d;
    end
  end

  assign w_bit = (w_rxs & r_rxs_d) | (w_rxs & r_rxs_d2) | (r_rxs_d & r_rxs_d2);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rxs_d <= 1'b1;
    else        r_rxs_d <= w_rxs;
  end

  assign w_bit = w_rxs;
`endif

  assign w_start   = r_rxs_d & ~w_rxs;
  assign w_tick    = (r_cnt == '0);
  assign w_div_eff = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div_l <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (r_valid && rx.rx_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_div_l <= w_div_eff;
            r_cnt   <= (w_div_eff >> 1) - 1'b1;
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_bit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_div_l - 1'b1;
            r_idx   <= '0;
            r_state <= DATA;
          end
        end

        DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
            r_cnt   <= r_div_l - 1'b1;
            if (r_idx == IDX_W'(UART_DATA_BITS - 1)) r_state <= STOP;
            else                                      r_idx   <= r_idx + 1'b1;
          end
        end

        STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_bit) begin
            // Newest byte always wins; overrun only if the held byte was not taken this cycle.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_data  <= r_shift;
            r_valid <= 1'b1;
            if (r_valid && !rx.rx_ready) r_ovr <= 1'b1;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= BREAK;
          end
        end

        BREAK: begin
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.rx_data  = r_data;
  assign rx.rx_valid = r_valid;
  assign frame_err   = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: table vectors, random back-to-back frames, corner sequences.
module tb_uart_rx_deser;
  import uart_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd   = 1'b1;
  logic [15:0] div   = 16'd32;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_rx_deser_if rxif ();

  uart_rx_deser #(.DIV_W(16), .DIV_MIN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .div       (div),
    .rx        (rxif),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         div_set;
    int         tx_div;
    logic [7:0] data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  logic [7:0] recv_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_ferr   = 0;
  int         n_ovr    = 0;
  int         cyc      = 0;
  int         start_cyc = 0;
  int         last_valid_cyc = 0;
  logic       prev_valid = 1'b0;

  // Monitor: observes the handshake and pulses mid-cycle, after the drivers have settled.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rxif.rx_valid && rxif.rx_ready) recv_q.push_back(rxif.rx_data);
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (rxif.rx_valid && !prev_valid) last_valid_cyc = cyc;
    prev_valid = rxif.rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_queue(input string name);
    int n;
    chk({name, "_count"}, recv_q.size(), exp_q.size());
    n = (recv_q.size() < exp_q.size()) ? recv_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", name, i), recv_q[i], exp_q[i]);
    recv_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial line driver: start bit, 8 data bits LSB first, stop_low extra low bits, then one high stop bit.
  task automatic send_frame(input logic [7:0] b, input int div_set, input int d,
                            input int stop_low, input int glitch_at, input bit scramble);
    for (int i = 0; i < (10 + stop_low) * d; i++) begin
      int   bi;
      logic v;
      bi = i / d;
      @(negedge clk);
      if (i == 0) begin
        div       = 16'(div_set);
        start_cyc = cyc;
      end
      if (scramble && i == d) div = 16'($urandom);
      if (bi == 0)                 v = 1'b0;
      else if (bi <= 8)            v = b[bi-1];
      else if (bi < 9 + stop_low)  v = 1'b0;
      else                         v = 1'b1;
      if (i == glitch_at) v = ~v;
      rxd = v;
    end
    div = 16'(div_set);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] g;

    vecs[0] = '{32, 32, 8'hA5, 8'hA5};
    vecs[1] = '{16, 16, 8'h3C, 8'h3C};
    vecs[2] = '{2,  4,  8'h5A, 8'h5A};
    vecs[3] = '{0,  4,  8'hC3, 8'hC3};
    vecs[4] = '{4,  4,  8'hFF, 8'hFF};
    vecs[5] = '{7,  7,  8'h00, 8'h00};
    vecs[6] = '{13, 13, 8'h81, 8'h81};

    rxif.rx_ready = 1'b1;
    idle(3);
    chk("rst_valid", rxif.rx_valid, 0);
    chk("rst_data",  rxif.rx_data,  0);
    chk("rst_busy",  busy,          0);
    chk("rst_ferr",  frame_err,     0);
    chk("rst_ovr",   overrun,       0);
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      n_ferr = 0;
      n_ovr  = 0;
      send_frame(vecs[i].data, vecs[i].div_set, vecs[i].tx_div, 0, -1, 1'b0);
      exp_q.push_back(vecs[i].exp_data);
      idle(2 * vecs[i].tx_div + 4);
      if (i == 0) chk_rng("latency", last_valid_cyc - start_cyc, 300, 315);
      check_queue($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ferr", i), n_ferr, 0);
      chk($sformatf("vec%0d_ovr", i),  n_ovr,  0);
      chk($sformatf("vec%0d_busy", i), busy,   0);
    end

    n_ferr = 0;
    n_ovr  = 0;
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 32, 32, 0, -1, 1'b1);
    end
    idle(70);
    check_queue("b2b");
    chk("b2b_ferr", n_ferr, 0);
    chk("b2b_ovr",  n_ovr,  0);

    n_ferr = 0;
    send_frame(8'h3C, 32, 32, 2, -1, 1'b0);
    idle(5);
    chk("ferr_pulse", n_ferr, 1);
    check_queue("ferr_nobyte");
    send_frame(8'h5A, 32, 32, 0, -1, 1'b0);
    exp_q.push_back(8'h5A);
    idle(70);
    check_queue("after_ferr");
    chk("ferr_once", n_ferr, 1);

    n_ferr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rxd = (i < 8) ? 1'b0 : 1'b1;
      if (i == 6) begin
        #1;
        chk("glitch_busy", busy, 1);
      end
    end
    idle(40);
    chk("glitch_idle", busy, 0);
    chk("glitch_ferr", n_ferr, 0);
    check_queue("glitch_nobyte");

    n_ovr = 0;
    rxif.rx_ready = 1'b0;
    send_frame(8'h11, 32, 32, 0, -1, 1'b0);
    send_frame(8'h22, 32, 32, 0, -1, 1'b0);
    idle(10);
    chk("ovr_pulse", n_ovr, 1);
    chk("ovr_valid", rxif.rx_valid, 1);
    chk("ovr_data",  rxif.rx_data,  8'h22);
    @(negedge clk);
    rxif.rx_ready = 1'b1;
    exp_q.push_back(8'h22);
    idle(3);
    check_queue("ovr_drain");
    chk("ovr_cleared", rxif.rx_valid, 0);

    for (int i = 0; i < 32 * 4; i++) begin
      @(negedge clk);
      rxd = (i < 32) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    chk("midrst_busy",  busy,          0);
    chk("midrst_valid", rxif.rx_valid, 0);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h81, 32, 32, 0, -1, 1'b0);
    exp_q.push_back(8'h81);
    idle(70);
    check_queue("midrst");

    // One-clock high glitch at the centre of bit 3: a direct sample flips that bit, a majority vote rejects it.
`ifdef UART_RX_MAJORITY_EN
    g = 8'h00;
`else
    g = 8'h08;
`endif
    send_frame(8'h00, 32, 32, 0, 32 * 4 + 16, 1'b0);
    exp_q.push_back(g);
    idle(70);
    check_queue("bit3_glitch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
